ps2_scan_rx: RTL
================

Name: ps2_scan_rx

Overview:
- Upstream stage of the key-event logic. Deframes raw PS/2 keyboard clock/data into 8-bit scan codes and buffers them in a small FIFO.
- Presents the current head byte as `data` with a `ready` flag. The consumer (key counter / decode stage) pops bytes with an active-low `nextdata_n` strobe.
- Also flags frame errors and FIFO overflow.

Parameters:
- FIFO_DEPTH, 8, number of buffered scan codes; must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 2048, clk cycles without a ps2_clk falling edge before a partial frame is abandoned. Used only with PS2_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- clr  input  1  asynchronous active-high reset
- ps2_clk  input  1  raw keyboard clock, asynchronous to clk
- ps2_data  input  1  raw keyboard data, asynchronous to clk
- nextdata_n  input  1  active-low pop request from consumer
- data  output  8  scan code at FIFO head; valid only while ready=1
- ready  output  1  FIFO non-empty
- overflow  output  1  sticky: a frame was dropped because the FIFO was full
- frame_err  output  1  one-cycle pulse: parity, start or stop error, or timeout abort

Behaviour:
- Reset: clock `clk`; reset `clr` is asynchronous, active-high. On reset:
  - ready=0, data=8'h00, overflow=0, frame_err=0.
  - FIFO pointers=0, FSM=IDLE, synchroniser flops=1.
- Input sync: ps2_clk passes through a 3-flop chain (2 sync, 1 history).
  - fall = (history==1 && sync==0). This gives 3 clk cycles of latency from pin to fall.
  - ps2_data is 2-flop synchronised and sampled on the cycle fall=1.
- FSM, advancing only on cycles where fall=1:
  - IDLE: data bit 0 → DATA, bit counter cleared. Data bit 1 → stay IDLE (spurious edge ignored, no error).
  - DATA: shift sampled bit in LSB-first. After the 8th bit → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: frame is good if stop bit==1 and (data bits + parity bit) contain an odd number of 1s.
    - Good frame: push the byte, then → IDLE.
    - Bad frame: frame_err=1 for one cycle, byte discarded, → IDLE.
- FIFO:
  - Push happens on the cycle of the stop-bit fall. ready is high from the next cycle.
  - data = mem[rd_ptr] while ready=1; it holds 8'h00 when empty.
  - Pop happens when nextdata_n==0 && ready==1. rd_ptr advances, and the new head appears the next cycle.
  - Pop while empty: ignored.
  - Full (count==FIFO_DEPTH) with push and no pop: byte dropped, overflow set. overflow stays set until reset.
  - Full with push and pop on the same cycle: both take effect, count unchanged, no overflow.
  - Push and pop on the same cycle when count==1: count stays 1, new head byte.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide. Full/empty is detected by MSB compare; pointers wrap naturally.
- The block does not interpret F0/E0 codes; every valid byte is forwarded.
- A reset mid-frame discards the partial frame. The FSM restarts in IDLE.

Optional Feature:
- Macro: PS2_TIMEOUT_EN.
- Defined:
  - A counter clears on every fall and increments while FSM != IDLE.
  - When it reaches TIMEOUT_CYCLES, FSM → IDLE, frame_err pulses once and the partial byte is discarded. The counter then clears.
- Undefined: no counter is built. A partial frame waits indefinitely for further edges.

Test Plan:
- Frame 0x1C (bits 0,00111000,parity 0,stop 1), each ps2_clk half-period 20 clk → ready=1 and data=8'h1C 4 clk after the final ps2_clk fall; frame_err stays 0.
- Frame 0xF0 with parity bit 0 (should be 1) → frame_err single pulse, ready stays 0, FIFO unchanged.
- 9 good frames 0x01..0x09 without popping → overflow=1 after the 9th. Then 8 pops yield 0x01..0x08 and ready=0; overflow remains 1.
- FIFO full; hold nextdata_n=0 for 1 cycle on the same cycle as the 9th stop-bit fall → no overflow; head 0x02, tail 0x09, count 8.
- Assert clr after 5 bits of a frame, release, send 0x2A → data=8'h2A, ready=1, no frame_err.
- With PS2_TIMEOUT_EN: send start + 3 bits then stop toggling → frame_err pulse at TIMEOUT_CYCLES clk after the last fall. Then a full 0x1C frame → data=8'h1C.

Source files
------------

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard deframer with scan-code FIFO (optional timeout: PS2_TIMEOUT_EN)
module ps2_scan_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // [0] first sync stage, [1] synchronised level, [2] history for edge detect
    logic [2:0]  clk_sync_q, clk_sync_d;
    logic [1:0]  dat_sync_q, dat_sync_d;
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic        frame_err_q, frame_err_d;
    logic        overflow_q, overflow_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [FIFO_DEPTH];

    logic fall;
    logic bit_in;
    logic push_req;
    logic do_push;
    logic pop;
    logic empty;
    logic full;
    logic timeout;

    assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_in = dat_sync_q[1];

    // Shift the raw pins into their synchroniser chains
    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
    end

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // A partial frame is abandoned once the keyboard stays silent too long
    always_comb begin
        timeout  = (state_q != S_IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES));
        to_cnt_d = to_cnt_q;
        if (fall || timeout) begin
            to_cnt_d = '0;
        end else if (state_q != S_IDLE) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Frame deframer: start, 8 data bits LSB first, odd parity, stop
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!bit_in) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_d = bit_in;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    if (bit_in && (^{shift_q, parity_q})) begin
                        push_req = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (timeout) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
        end
    end

    // FIFO pointer and overflow control; a pop frees room for a same-cycle push
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !nextdata_n && !empty;
        do_push    = push_req && (!full || pop);
        overflow_d = overflow_q | (push_req && full && !pop);
        wr_ptr_d   = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    // Control and status registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_sync_q  <= 3'b111;
            dat_sync_q  <= 2'b11;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage; the completed byte still sits in the shift register during STOP
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    assign ready     = !empty;
    assign data      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
